// File: rtl/alu_op_decoder_if.sv
// rtl/alu_op_decoder_if.sv - ALU operand decoder types and issue/ALU-side bus interface

package alu_op_decoder_pkg;

    typedef enum logic [6:0] {
        F7_NORMAL = 7'h00,
        F7_ALT    = 7'h20
    } alu_funct7_e;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SRL  = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } alu_funct3_e;

    // One buffered decoded operation (used for both the output and the skid entry).
    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        alu_funct7_e funct7;
        alu_funct3_e funct3;
        logic [4:0]  rd;
        logic        illegal;
    } entry_t;

endpackage

interface alu_op_decoder_if;
    import alu_op_decoder_pkg::*;

    // Issue side: instruction plus register-file read data
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;

    // ALU side: decoded operation
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] operand_1_o;
    logic [31:0] operand_2_o;
    alu_funct7_e funct7_o;
    alu_funct3_e funct3_o;
    logic [4:0]  rd_o;
    logic        illegal_o;

    // Driver of instructions and consumer of decoded ops
    modport master (
        output in_valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, operand_1_o, operand_2_o,
               funct7_o, funct3_o, rd_o, illegal_o
    );

    // The decoder itself
    modport slave (
        input  in_valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i, out_ready_i,
        output in_ready_o, out_valid_o, operand_1_o, operand_2_o,
               funct7_o, funct3_o, rd_o, illegal_o
    );

endinterface

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - RV32I OP/OP-IMM/LUI/AUIPC decoder with output + skid buffer

module alu_op_decoder
    import alu_op_decoder_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    alu_op_decoder_if.slave      bus
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;

    assign opcode = bus.instr_i[6:0];
    assign rd     = bus.instr_i[11:7];
    assign f3     = bus.instr_i[14:12];
    assign f7     = bus.instr_i[31:25];
    assign imm_i  = {{(XLEN-12){bus.instr_i[31]}}, bus.instr_i[31:20]};
    assign imm_u  = {bus.instr_i[31:12], 12'b0};

    entry_t dec;
    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;

    logic accept;
    logic out_free;

    assign accept   = bus.in_valid_i & in_ready_q;
    assign out_free = ~out_valid_q | bus.out_ready_i;

    // Decode the incoming instruction; anything not provably legal collapses to an inert ADD 0,0.
    always_comb begin
        logic legal;
        legal       = 1'b0;
        dec         = '0;
        dec.funct7  = F7_NORMAL;
        dec.funct3  = F3_ADD;
        case (opcode)
            OPC_OP: begin
                legal      = (f7 == 7'h00) ||
                             ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
                dec.op1    = bus.rs1_data_i;
                dec.op2    = bus.rs2_data_i;
                dec.funct3 = alu_funct3_e'(f3);
                dec.funct7 = (f7 == 7'h20) ? F7_ALT : F7_NORMAL;
            end
            OPC_OPIMM: begin
                dec.op1    = bus.rs1_data_i;
                dec.funct3 = alu_funct3_e'(f3);
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    // Shift-immediates carry the shamt and keep funct7 to select SRA vs SRL.
                    dec.op2    = {27'b0, bus.instr_i[24:20]};
                    dec.funct7 = (f7 == 7'h20) ? F7_ALT : F7_NORMAL;
                    legal      = (f7 == 7'h00) || ((f3 == 3'b101) && (f7 == 7'h20));
                end else begin
                    // imm[11:5] is not a funct7 here, so never let it turn ADDI into a subtract.
                    dec.op2    = imm_i;
                    dec.funct7 = F7_NORMAL;
                    legal      = 1'b1;
                end
            end
            OPC_LUI: begin
                legal   = 1'b1;
                dec.op2 = imm_u;
            end
            OPC_AUIPC: begin
                legal   = 1'b1;
                dec.op1 = bus.pc_i;
                dec.op2 = imm_u;
            end
            default: legal = 1'b0;
        endcase
        if (legal) begin
            dec.rd = rd;
        end else begin
            dec         = '0;
            dec.funct7  = F7_NORMAL;
            dec.funct3  = F3_ADD;
            dec.illegal = 1'b1;
        end
    end

    // Buffer next state: the skid entry always drains into the output first so order is kept.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = ~skid_valid_d;
    end

    // State registers with synchronous reset to an empty buffer and inert output fields.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q         <= '{op1: '0, op2: '0, funct7: F7_NORMAL, funct3: F3_ADD, rd: '0, illegal: 1'b0};
            skid_q        <= '{op1: '0, op2: '0, funct7: F7_NORMAL, funct3: F3_ADD, rd: '0, illegal: 1'b0};
            out_valid_q   <= 1'b0;
            skid_valid_q  <= 1'b0;
            in_ready_q    <= 1'b1;
        end else begin
            out_q         <= out_d;
            skid_q        <= skid_d;
            out_valid_q   <= out_valid_d;
            skid_valid_q  <= skid_valid_d;
            in_ready_q    <= in_ready_d;
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.operand_1_o = out_q.op1;
    assign bus.operand_2_o = out_q.op2;
    assign bus.funct7_o    = out_q.funct7;
    assign bus.funct3_o    = out_q.funct3;
    assign bus.rd_o        = out_q.rd;
    assign bus.illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// tb/tb_alu_op_decoder.sv - directed self-checking bench for alu_op_decoder

module tb_alu_op_decoder;

    logic clk_i;
    logic rst_i;
    logic flush_i;
    int   total;
    int   bad;

    alu_op_decoder_if bus ();

    alu_op_decoder #(.XLEN(32)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .bus     (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        bus.in_valid_i = 1'b1;
        bus.instr_i    = instr;
        bus.pc_i       = pc;
        bus.rs1_data_i = rs1;
        bus.rs2_data_i = rs2;
    endtask

    // Send one instruction with out_ready high and check the op presented one cycle later.
    task automatic one(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] e_op1, input logic [31:0] e_op2,
                       input logic [6:0] e_f7, input logic [2:0] e_f3,
                       input logic [4:0] e_rd, input logic e_ill);
        drive(instr, pc, rs1, rs2);
        step();
        bus.in_valid_i = 1'b0;
        check({tag, ".valid"}, 32'(bus.out_valid_o), 32'd1);
        check({tag, ".op1"},   bus.operand_1_o, e_op1);
        check({tag, ".op2"},   bus.operand_2_o, e_op2);
        check({tag, ".f7"},    32'(bus.funct7_o), 32'(e_f7));
        check({tag, ".f3"},    32'(bus.funct3_o), 32'(e_f3));
        check({tag, ".rd"},    32'(bus.rd_o), 32'(e_rd));
        check({tag, ".ill"},   32'(bus.illegal_o), 32'(e_ill));
    endtask

    localparam logic [31:0] ADD_X3 = 32'h002081B3;

    initial begin
        int sent;
        int got_n;
        logic fire_in;
        logic fire_out;
        logic [31:0] seen;

        total = 0;
        bad   = 0;
        rst_i = 1'b1;
        flush_i = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        bus.instr_i     = '0;
        bus.pc_i        = '0;
        bus.rs1_data_i  = '0;
        bus.rs2_data_i  = '0;
        step();
        step();
        rst_i = 1'b0;

        check("rst.valid", 32'(bus.out_valid_o), 32'd0);
        check("rst.ready", 32'(bus.in_ready_o), 32'd1);
        check("rst.op1",   bus.operand_1_o, 32'd0);
        check("rst.op2",   bus.operand_2_o, 32'd0);
        check("rst.f7",    32'(bus.funct7_o), 32'd0);
        check("rst.f3",    32'(bus.funct3_o), 32'd0);
        check("rst.ill",   32'(bus.illegal_o), 32'd0);

        //   tag      instr          pc        rs1           rs2   op1           op2           f7     f3    rd ill
        one("add",   ADD_X3,        32'h0,    32'd5,        32'd7, 32'd5,        32'd7,        7'h00, 3'd0, 5'd3, 1'b0);
        one("sub",   32'h402081B3,  32'h0,    32'd9,        32'd4, 32'd9,        32'd4,        7'h20, 3'd0, 5'd3, 1'b0);
        one("sll20", 32'h402091B3,  32'h0,    32'd9,        32'd4, 32'd0,        32'd0,        7'h00, 3'd0, 5'd0, 1'b1);
        one("addi",  32'hFFF00093,  32'h0,    32'd0,        32'd3, 32'd0,        32'hFFFFFFFF, 7'h00, 3'd0, 5'd1, 1'b0);
        one("srai",  32'h40435293,  32'h0,    32'h80000000, 32'd3, 32'h80000000, 32'd4,        7'h20, 3'd5, 5'd5, 1'b0);
        one("slli20",32'h40431293,  32'h0,    32'h80000000, 32'd3, 32'd0,        32'd0,        7'h00, 3'd0, 5'd0, 1'b1);
        one("lui",   32'h12345137,  32'h0,    32'd77,       32'd3, 32'd0,        32'h12345000, 7'h00, 3'd0, 5'd2, 1'b0);
        one("auipc", 32'h00001097,  32'h100,  32'd77,       32'd3, 32'h100,      32'h1000,     7'h00, 3'd0, 5'd1, 1'b0);
        one("mul",   32'h022081B3,  32'h0,    32'd5,        32'd7, 32'd0,        32'd0,        7'h00, 3'd0, 5'd0, 1'b1);

        step();
        check("idle.valid", 32'(bus.out_valid_o), 32'd0);

        // Back-pressure: four ADDs tagged by rs1 = 10..13, ALU stalled for three edges.
        bus.out_ready_i = 1'b0;
        drive(ADD_X3, 32'h0, 32'd10, 32'd0);
        step();
        drive(ADD_X3, 32'h0, 32'd11, 32'd0);
        check("bp.ready1", 32'(bus.in_ready_o), 32'd1);
        step();
        drive(ADD_X3, 32'h0, 32'd12, 32'd0);
        check("bp.ready2", 32'(bus.in_ready_o), 32'd0);
        check("bp.hold1",  bus.operand_1_o, 32'd10);
        step();
        check("bp.ready3", 32'(bus.in_ready_o), 32'd0);
        check("bp.hold2",  bus.operand_1_o, 32'd10);
        check("bp.valid",  32'(bus.out_valid_o), 32'd1);

        bus.out_ready_i = 1'b1;
        sent  = 2;
        got_n = 0;
        for (int cyc = 0; cyc < 30 && got_n < 4; cyc++) begin
            fire_in  = bus.in_valid_i & bus.in_ready_o;
            fire_out = bus.out_valid_o & bus.out_ready_i;
            seen     = bus.operand_1_o;
            step();
            if (fire_out) begin
                check("bp.order", seen, 32'(10 + got_n));
                got_n++;
            end
            if (fire_in) begin
                sent++;
                if (sent < 4) drive(ADD_X3, 32'h0, 32'(10 + sent), 32'd0);
                else bus.in_valid_i = 1'b0;
            end
        end
        check("bp.count", 32'(got_n), 32'd4);
        bus.in_valid_i = 1'b0;
        step();
        check("bp.drained", 32'(bus.out_valid_o), 32'd0);

        // Flush with both entries full; the op offered during the flush is dropped.
        bus.out_ready_i = 1'b0;
        drive(ADD_X3, 32'h0, 32'd20, 32'd0);
        step();
        drive(ADD_X3, 32'h0, 32'd21, 32'd0);
        step();
        check("fl.full", 32'(bus.in_ready_o), 32'd0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        bus.in_valid_i = 1'b0;
        check("fl.valid", 32'(bus.out_valid_o), 32'd0);
        check("fl.ready", 32'(bus.in_ready_o), 32'd1);
        bus.out_ready_i = 1'b1;
        step();
        check("fl.empty", 32'(bus.out_valid_o), 32'd0);

        // Reset with both entries full.
        bus.out_ready_i = 1'b0;
        drive(32'h40435293, 32'h0, 32'd30, 32'd0);
        step();
        drive(ADD_X3, 32'h0, 32'd31, 32'd0);
        step();
        bus.in_valid_i = 1'b0;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("rs.valid", 32'(bus.out_valid_o), 32'd0);
        check("rs.ready", 32'(bus.in_ready_o), 32'd1);
        check("rs.op1",   bus.operand_1_o, 32'd0);
        check("rs.f7",    32'(bus.funct7_o), 32'd0);
        check("rs.f3",    32'(bus.funct3_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
